// File: rtl/button_debounce.sv
// Multi-channel button debouncer.
// Each channel goes through a two-flop synchronizer. A counter then has to see DEBOUNCE
// consecutive mismatching samples before the debounced level changes. Registered rise/fall
// pulses line up with the cycle in which db_out takes its new value.
module button_debounce #(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned DEBOUNCE = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn_in,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int unsigned CW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE - 1);

    logic [WIDTH-1:0]         s1_q, s2_q;
    logic [WIDTH-1:0]         stable_q, stable_d;
    logic [WIDTH-1:0]         rise_q, fall_q;
    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

    // Next-state for counters and stable levels. Any sample that agrees with the current
    // stable level clears the count, so a bounce always restarts the full window.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // State registers; reset overrides everything, including a level change due this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
        end else begin
            s1_q     <= btn_in;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= stable_d & ~stable_q;
            fall_q   <= ~stable_d & stable_q;
        end
    end

    assign db_out = stable_q;
    assign rise   = rise_q;
    assign fall   = fall_q;

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce (WIDTH=2, DEBOUNCE=4).
// Reference model: a channel's level flips once the last DEBOUNCE synchronized samples all
// differ from it. The synchronized sample is the raw input delayed by two edges.
module tb_button_debounce;

    localparam int W = 2;
    localparam int D = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] btn_in;
    logic [W-1:0] db_out, rise, fall;

    int checks;
    int errors;

    button_debounce #(
        .WIDTH   (W),
        .DEBOUNCE(D)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .btn_in(btn_in),
        .db_out(db_out),
        .rise  (rise),
        .fall  (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: hist[c][0] is the newest raw sample, hist[c][j] is the one j edges older.
    logic         hist [W][D+1];
    logic [W-1:0] m_db, m_rise, m_fall;

    // Channels whose last D synchronized samples (hist[1..D]) all disagree with the level.
    function automatic logic [W-1:0] flips();
        logic [W-1:0] f;
        for (int c = 0; c < W; c++) begin
            f[c] = 1'b1;
            for (int j = 1; j <= D; j++) begin
                if (hist[c][j] == m_db[c]) f[c] = 1'b0;
            end
        end
        return f;
    endfunction

    // Reference model, advanced on every rising edge.
    always @(posedge clk) begin
        if (rst) begin
            m_db   <= '0;
            m_rise <= '0;
            m_fall <= '0;
            for (int c = 0; c < W; c++) begin
                for (int j = 0; j <= D; j++) hist[c][j] <= 1'b0;
            end
        end else begin
            m_rise <= flips() & ~m_db;
            m_fall <= flips() & m_db;
            m_db   <= m_db ^ flips();
            for (int c = 0; c < W; c++) begin
                for (int j = 1; j <= D; j++) hist[c][j] <= hist[c][j-1];
                hist[c][0] <= btn_in[c];
            end
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one edge and compare every output against the model.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        chk("db_model", db_out, m_db);
        chk("rise_model", rise, m_rise);
        chk("fall_model", fall, m_fall);
        chk("rise_fall_excl", rise & fall, 2'b00);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        btn_in = '0;
        @(negedge clk);
        steps(2);
        chk("reset_db", db_out, 2'b00);
        chk("reset_rise", rise, 2'b00);
        chk("reset_fall", fall, 2'b00);
        rst = 1'b0;
        steps(2);

        // Clean press on channel 0: the sampling edge is the next one, db rises 5 edges later.
        btn_in = 2'b01;
        steps(5);
        chk("press_db_early", db_out, 2'b00);
        step();
        chk("press_db", db_out, 2'b01);
        chk("press_rise", rise, 2'b01);
        step();
        chk("press_rise_gone", rise, 2'b00);
        chk("press_db_hold", db_out, 2'b01);

        // Release: fall pulse after the same latency, with no rise.
        btn_in = 2'b00;
        steps(5);
        chk("release_db_early", db_out, 2'b01);
        step();
        chk("release_db", db_out, 2'b00);
        chk("release_fall", fall, 2'b01);
        chk("release_rise", rise, 2'b00);
        steps(3);

        // Glitch: three high samples are one short of a full window.
        btn_in = 2'b01;
        steps(3);
        btn_in = 2'b00;
        steps(8);
        chk("glitch_db", db_out, 2'b00);

        // Bounce 1,0,1,1,0 then hold 1: the window restarts at the final 0->1 sample.
        btn_in = 2'b01; step();
        btn_in = 2'b00; step();
        btn_in = 2'b01; step();
        step();
        btn_in = 2'b00; step();
        btn_in = 2'b01;
        steps(5);
        chk("bounce_db_early", db_out, 2'b00);
        step();
        chk("bounce_db", db_out, 2'b01);
        chk("bounce_rise", rise, 2'b01);
        btn_in = 2'b00;
        steps(8);

        // Both channels pressed on the same edge change together.
        btn_in = 2'b11;
        steps(5);
        chk("both_db_early", db_out, 2'b00);
        step();
        chk("both_db", db_out, 2'b11);
        chk("both_rise", rise, 2'b11);
        btn_in = 2'b00;
        steps(8);
        chk("both_release", db_out, 2'b00);

        // Reset mid-count (counter at 2), input stays high; a fresh window starts after reset.
        btn_in = 2'b01;
        steps(4);
        rst = 1'b1;
        step();
        chk("midrst_db", db_out, 2'b00);
        chk("midrst_rise", rise, 2'b00);
        rst = 1'b0;
        steps(5);
        chk("postrst_db_early", db_out, 2'b00);
        step();
        chk("postrst_db", db_out, 2'b01);
        chk("postrst_rise", rise, 2'b01);

        // Randomized activity: slow random toggling per channel, occasional one-edge reset.
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < W; c++) begin
                if ($urandom_range(5) == 0) btn_in[c] = ~btn_in[c];
            end
            rst = ($urandom_range(79) == 0);
            step();
        end
        rst = 1'b0;
        steps(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
